// File: rtl/program_control_unit.sv
// program_control_unit: instruction fetch, program counter and decode for the 4-bit micro.
// Latency: one fetch per RUN cycle; the decode is combinational on ir. A taken jump costs one bubble cycle.
// Backpressure: optional stall (build macro PCU_STALL_EN) holds pc/ir/ir_valid and forces reg_en to 0.
//
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   stall             (PCU_STALL_EN only) freeze fetch while in RUN
//   pm_data           instruction at pm_address (same-cycle program memory)
//   r_eq_0            zero flag from computational_unit, used by JNZ
//   pm_address, pc    program counter
//   ir, nibble_ir     instruction register and its low nibble
//   sync_reset        high until the FSM reaches RUN
//   reg_en            [0]x0 [1]x1 [2]y0 [3]y1 [4]r [5]m [6]i [7]dm [8]o_reg
//   source_sel        bus source: 0-7 registers/dm, 8 ir nibble, 9 i_pins
//   i_sel/x_sel/y_sel i update mode and ALU operand selects
module program_control_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
`ifdef PCU_STALL_EN
  input  logic            stall,
`endif
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  output logic [PC_W-1:0] pm_address,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic            sync_reset,
  output logic [8:0]      reg_en,
  output logic [3:0]      source_sel,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic [3:0]      nibble_ir
);

  typedef enum logic [1:0] {RST1 = 2'd0, RST2 = 2'd1, RUN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            run;
  logic            hold;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RST1;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST1:    state_d = RST2;
      RST2:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RST1;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run        = (state_q == RUN);
    sync_reset = (state_q != RUN);
  end

`ifdef PCU_STALL_EN
  // stall only matters once fetching; the reset sequence runs regardless.
  assign hold = stall & run;
`else
  assign hold = 1'b0;
`endif

  // ---------------- instruction classes ----------------
  logic is_load, is_mov, is_alu, is_jmp, is_jnz, jump_taken;

  always_comb begin
    is_load = ~ir_q[7];
    is_mov  = (ir_q[7:6] == 2'b10);
    is_alu  = (ir_q[7:5] == 3'b110);
    is_jmp  = (ir_q[7:4] == 4'b1110);
    is_jnz  = (ir_q[7:4] == 4'b1111);
    // A squashed slot (ir_valid low) never redirects the pc.
    jump_taken = ir_valid_q & (is_jmp | (is_jnz & ~r_eq_0));
  end

  // ---------------- fetch datapath ----------------
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (run && !hold) begin
      ir_d       = pm_data;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + PC_W'(1);
      if (jump_taken) begin
        // Target replaces only the low nibble of the already-incremented pc;
        // the word fetched this cycle is discarded.
        pc_d       = {pc_q[PC_W-1:4], ir_q[3:0]};
        ir_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= '0;
      ir_q       <= 8'h00;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // ---------------- decode ----------------
  logic [2:0] dst, src;
  logic [8:0] dec_en;

  always_comb begin
    dst        = is_load ? ir_q[6:4] : ir_q[5:3];
    src        = ir_q[2:0];
    dec_en     = 9'h000;
    source_sel = 4'd0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    if (ir_valid_q) begin
      if (is_load || is_mov) begin
        unique case (dst)
          3'd0: dec_en[0] = 1'b1;
          3'd1: dec_en[1] = 1'b1;
          3'd2: dec_en[2] = 1'b1;
          3'd3: dec_en[3] = 1'b1;
          3'd4: dec_en[8] = 1'b1;
          3'd5: dec_en[5] = 1'b1;
          3'd6: dec_en[6] = 1'b1;
          default: dec_en[7] = 1'b1;
        endcase
        if (is_load)         source_sel = 4'd8;
        else if (src == dst) source_sel = 4'd9;   // self-move reads the input pins
        else                 source_sel = {1'b0, src};
        // Touching dm (as destination or MOV source) post-increments i,
        // unless i itself is being loaded this cycle.
        if ((dst == 3'd7 || (is_mov && src == 3'd7)) && dst != 3'd6) begin
          dec_en[6] = 1'b1;
          i_sel     = 1'b1;
        end
      end else if (is_alu) begin
        dec_en[4]  = 1'b1;
        x_sel      = ir_q[4];
        y_sel      = ir_q[3];
        source_sel = 4'd9;
      end
    end
  end

  assign reg_en     = hold ? 9'h000 : dec_en;
  assign pm_address = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign nibble_ir  = ir_q[3:0];

endmodule

// File: tb/tb_program_control_unit.sv
// tb_program_control_unit: scoreboard bench for program_control_unit.
// Latency: expectations are queued before each edge and checked 1 time unit after it.
// Backpressure: exercises stall only when built with PCU_STALL_EN.
module tb_program_control_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       r_eq_0 = 1'b0;
`ifdef PCU_STALL_EN
  logic       stall = 1'b0;
`endif
  logic [7:0] pm [256];
  logic [7:0] pm_data;
  logic [7:0] pm_address, pc, ir;
  logic       sync_reset, i_sel, x_sel, y_sel;
  logic [8:0] reg_en;
  logic [3:0] source_sel, nibble_ir;

  always #5 clk = ~clk;
  assign pm_data = pm[pm_address];

  program_control_unit #(.PC_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef PCU_STALL_EN
    .stall(stall),
`endif
    .pm_data(pm_data), .r_eq_0(r_eq_0),
    .pm_address(pm_address), .pc(pc), .ir(ir), .sync_reset(sync_reset),
    .reg_en(reg_en), .source_sel(source_sel),
    .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel), .nibble_ir(nibble_ir)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic       sync;
    logic [8:0] en;
    logic [3:0] src;
    logic       isel, xsel, ysel;
    logic [7:0] ir;
    logic       chk_dec;
  } exp_t;

  exp_t       exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_pc;
  logic [7:0] cur_ir;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, expv);
    end
  endtask

  function automatic logic [8:0] dst_bit(input logic [2:0] d);
    case (d)
      3'd0: return 9'h001;
      3'd1: return 9'h002;
      3'd2: return 9'h004;
      3'd3: return 9'h008;
      3'd4: return 9'h100;
      3'd5: return 9'h020;
      3'd6: return 9'h040;
      default: return 9'h080;
    endcase
  endfunction

  // Reference decode of a valid instruction word.
  function automatic exp_t ref_dec(input logic [7:0] w);
    exp_t e;
    logic [2:0] d, s;
    e = '0;
    e.ir = w;
    e.chk_dec = 1'b1;
    if (w[7] == 1'b0) begin
      d = w[6:4];
      e.src = 4'd8;
      e.en = dst_bit(d);
      if (d == 3'd7) begin e.en[6] = 1'b1; e.isel = 1'b1; end
    end else if (w[7:6] == 2'b10) begin
      d = w[5:3];
      s = w[2:0];
      e.src = (s == d) ? 4'd9 : {1'b0, s};
      e.en = dst_bit(d);
      if ((d == 3'd7 || s == 3'd7) && d != 3'd6) begin e.en[6] = 1'b1; e.isel = 1'b1; end
    end else if (w[7:5] == 3'b110) begin
      e.en = 9'h010;
      e.xsel = w[4];
      e.ysel = w[3];
      e.src = 4'd9;
    end else begin
      e.chk_dec = 1'b0;   // jumps: only reg_en/pc/ir are defined
    end
    return e;
  endfunction

  task automatic tick_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_underflow: no expectation queued");
      $fatal(1);
    end
    e = exp_q.pop_front();
    check_eq("pc", pc, e.pc);
    check_eq("pm_address", pm_address, e.pc);
    check_eq("sync_reset", sync_reset, e.sync);
    check_eq("reg_en", reg_en, e.en);
    check_eq("ir", ir, e.ir);
    check_eq("nibble_ir", nibble_ir, e.ir[3:0]);
    if (e.chk_dec) begin
      check_eq("source_sel", source_sel, e.src);
      check_eq("i_sel", i_sel, e.isel);
      check_eq("x_sel", x_sel, e.xsel);
      check_eq("y_sel", y_sel, e.ysel);
    end
  endtask

  task automatic step_fetch();
    exp_t e;
    e = ref_dec(pm[exp_pc]);
    cur_ir = pm[exp_pc];
    exp_pc = exp_pc + 8'd1;
    e.pc = exp_pc;
    e.sync = 1'b0;
    exp_q.push_back(e);
    tick_and_check();
  endtask

  task automatic step_bubble(input logic [7:0] new_pc);
    exp_t e;
    e = '0;
    e.ir = pm[exp_pc];
    cur_ir = pm[exp_pc];
    e.pc = new_pc;
    exp_pc = new_pc;
    exp_q.push_back(e);
    tick_and_check();
  endtask

  task automatic step_rst(input logic s);
    exp_t e;
    e = '0;
    e.sync = s;
    e.chk_dec = 1'b1;
    exp_q.push_back(e);
    tick_and_check();
  endtask

`ifdef PCU_STALL_EN
  task automatic step_stall();
    exp_t e;
    e = ref_dec(cur_ir);
    e.en = 9'h000;
    e.pc = exp_pc;
    exp_q.push_back(e);
    tick_and_check();
  endtask
`endif

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_pc", pc, 0);
    check_eq("rst_sync", sync_reset, 1);
    check_eq("rst_reg_en", reg_en, 0);
    check_eq("rst_source_sel", source_sel, 0);
    check_eq("rst_ir", ir, 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc = 8'h00;
    cur_ir = 8'h00;
    step_rst(1'b1);   // edge 1: RST1 -> RST2
    step_rst(1'b0);   // edge 2: RST2 -> RUN, nothing fetched yet
  endtask

  task automatic fill_pm(input logic [7:0] v);
    for (int a = 0; a < 256; a++) pm[a] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    exp_t e;
    fill_pm(8'h00);
    #2;

    // All-zero memory: first RUN edge fetches LOAD x0.
    do_reset();
    repeat (3) step_fetch();

    // Directed decode patterns.
    pm[0] = 8'h55; pm[1] = 8'hB8; pm[2] = 8'h9B; pm[3] = 8'hD8; pm[4] = 8'hC3;
    pm[5] = 8'h6A; pm[6] = 8'h7C; pm[7] = 8'hB7; pm[8] = 8'h87; pm[9] = 8'hA2;
    do_reset();
    repeat (10) step_fetch();

    // JMP at 0x25 -> 0x23; the JMP at 0x26 sits in the squashed slot.
    fill_pm(8'h00);
    pm[8'h23] = 8'h12; pm[8'h25] = 8'hE3; pm[8'h26] = 8'hE0;
    r_eq_0 = 1'b1;
    do_reset();
    while (exp_pc != 8'h26) step_fetch();
    step_bubble(8'h23);
    step_fetch();
    step_fetch();

    // JNZ with r_eq_0=1 falls through without a bubble.
    pm[8'h25] = 8'hF3; pm[8'h26] = 8'h30;
    do_reset();
    while (exp_pc != 8'h26) step_fetch();
    step_fetch();

    // JNZ with r_eq_0=0 is taken.
    r_eq_0 = 1'b0;
    do_reset();
    while (exp_pc != 8'h26) step_fetch();
    step_bubble(8'h23);
    step_fetch();
    r_eq_0 = 1'b1;

    // Random non-jump program, run past the pc wrap, then reset mid-run at 0x40.
    for (int a = 0; a < 256; a++) begin
      w = 8'($urandom_range(0, 255));
      if (w[7:5] == 3'b111) w[7] = 1'b0;
      pm[a] = w;
    end
    do_reset();
    for (int k = 0; k < 300; k++) step_fetch();
    while (exp_pc != 8'h40) step_fetch();
    do_reset();
    repeat (4) step_fetch();

`ifdef PCU_STALL_EN
    stall = 1'b1;
    repeat (3) step_stall();
    stall = 1'b0;
    #1;
    e = ref_dec(cur_ir);
    check_eq("stall_resume_reg_en", reg_en, e.en);
    check_eq("stall_resume_pc", pc, exp_pc);
    repeat (3) step_fetch();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
